// File: rtl/shift_seq_unit_if.sv
// Purpose: groups the request/result signals of the sequential shifter.
// Ports  : start/op/data_in/n flow from master to slave;
//          data_out/busy/done flow from slave back to master.
interface shift_seq_unit_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] data_in;
  logic [CNT_W-1:0] n;
  logic [WIDTH-1:0] data_out;
  logic             busy;
  logic             done;

  // Requester side: issues operations and waits on done.
  modport master (
    output start, op, data_in, n,
    input  data_out, busy, done
  );

  // Shifter side.
  modport slave (
    input  start, op, data_in, n,
    output data_out, busy, done
  );
endinterface

// File: rtl/shift_seq_unit.sv
// Purpose : one-bit-per-clock shifter/rotator for SLL/SRL/SRA/ROL/ROR (others pass through).
// Latency : done pulses in the cycle after edge E_n (start edge = E0); n=0 -> 1 cycle, n=31 -> 32.
// Backpres: start is ignored while busy; accepted in IDLE or DONE (back-to-back allowed).
// Ports   : clk, reset (synchronous, active-high);
//           bus.start/op/data_in/n  request, latched on the accepting edge;
//           bus.data_out            working/result register, held until the next accepted start;
//           bus.busy                high while shifting; bus.done one-cycle result-valid pulse.
module shift_seq_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic          clk,
  input  logic          reset,
  shift_seq_unit_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [2:0]       op_q,    op_d;

  // Single-position step applied once per SHIFT cycle.
  function automatic logic [WIDTH-1:0] step(input logic [2:0] sel, input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    case (sel)
      OP_SLL:  r = {d[WIDTH-2:0], 1'b0};
      OP_SRL:  r = {1'b0, d[WIDTH-1:1]};
      OP_SRA:  r = {d[WIDTH-1], d[WIDTH-1:1]};
      OP_ROL:  r = {d[WIDTH-2:0], d[WIDTH-1]};
      OP_ROR:  r = {d[0], d[WIDTH-1:1]};
      default: r = d;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          data_d  = bus.data_in;
          op_d    = bus.op;
          cnt_d   = bus.n;
          // A zero amount skips SHIFT entirely; from DONE this keeps done high one more cycle.
          state_d = (bus.n == '0) ? ST_DONE : ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        data_d = step(op_q, data_q);
        cnt_d  = cnt_q - 1'b1;
        // cnt counts remaining steps including this one, so the last step is taken at cnt==1.
        if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      op_q    <= 3'b000;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  // Status outputs are pure decodes of the registered state.
  assign bus.data_out = data_q;
  assign bus.busy     = (state_q == ST_SHIFT);
  assign bus.done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_shift_seq_unit.sv
module tb_shift_seq_unit;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  logic [31:0] r;

  shift_seq_unit_if #(.WIDTH(32), .CNT_W(5)) bus ();

  shift_seq_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: whole-amount shift computed arithmetically.
  function automatic logic [31:0] ref_shift(input logic [2:0] op, input logic [31:0] d, input logic [4:0] nn);
    int k;
    k = int'(nn);
    case (op)
      3'b000: return d << k;
      3'b001: return d >> k;
      3'b010: return $unsigned($signed(d) >>> k);
      3'b011: return (k == 0) ? d : ((d << k) | (d >> (32 - k)));
      3'b100: return (k == 0) ? d : ((d >> k) | (d << (32 - k)));
      default: return d;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and follow it cycle by cycle. Called at #1 after an edge
  // with the DUT in IDLE or DONE. If chain is set, returns while done is high.
  task automatic run_op(input logic [2:0] op, input logic [31:0] d, input logic [4:0] nn,
                        input bit disturb, input bit chain);
    logic [31:0] exp;
    logic [31:0] rr;
    exp = ref_shift(op, d, nn);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.data_in = d;
    bus.n       = nn;
    tick();
    bus.start = 1'b0;
    for (int j = 0; j < int'(nn); j++) begin
      check("busy_during_shift", {31'b0, bus.busy}, 32'd1);
      check("done_before_end", {31'b0, bus.done}, 32'd0);
      rr = $urandom;
      bus.data_in = $urandom;
      bus.op      = rr[2:0];
      bus.n       = rr[7:3];
      if (disturb) bus.start = rr[8];
      tick();
    end
    bus.start = 1'b0;
    check("done_at_end", {31'b0, bus.done}, 32'd1);
    check("busy_at_end", {31'b0, bus.busy}, 32'd0);
    check("result", bus.data_out, exp);
    if (!chain) begin
      tick();
      check("done_pulse_len", {31'b0, bus.done}, 32'd0);
      check("busy_idle", {31'b0, bus.busy}, 32'd0);
      check("result_held", bus.data_out, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.op      = 3'b000;
    bus.data_in = 32'h0;
    bus.n       = 5'd0;
    tick();
    tick();
    check("reset_data", bus.data_out, 32'h0);
    check("reset_busy", {31'b0, bus.busy}, 32'd0);
    check("reset_done", {31'b0, bus.done}, 32'd0);
    reset = 1'b0;
    tick();

    // Reset for 2 cycles in the middle of a shift.
    bus.start = 1'b1; bus.op = 3'b011; bus.data_in = 32'hA5C3_0F96; bus.n = 5'd20;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    check("pre_reset_busy", {31'b0, bus.busy}, 32'd1);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_data", bus.data_out, 32'h0);
      check("rst_busy", {31'b0, bus.busy}, 32'd0);
      check("rst_done", {31'b0, bus.done}, 32'd0);
    end
    reset = 1'b0;
    tick();

    // Directed cases.
    run_op(3'b000, 32'h0000_0001, 5'd4,  1'b0, 1'b0);
    run_op(3'b010, 32'h8000_0000, 5'd31, 1'b0, 1'b0);
    run_op(3'b001, 32'h8000_0000, 5'd31, 1'b0, 1'b0);
    run_op(3'b100, 32'h0000_0001, 5'd1,  1'b0, 1'b0);
    run_op(3'b011, 32'h8000_0001, 5'd4,  1'b0, 1'b0);
    run_op(3'b000, 32'hDEAD_BEEF, 5'd0,  1'b0, 1'b0);
    run_op(3'b111, 32'h1234_5678, 5'd3,  1'b0, 1'b0);
    check("sll4_const", ref_shift(3'b000, 32'h1, 5'd4), 32'h0000_0010);
    check("rol4_const", ref_shift(3'b011, 32'h8000_0001, 5'd4), 32'h0000_0018);

    // Disturbed inputs during SHIFT, then back-to-back start in DONE with n=2.
    run_op(3'b001, 32'hF0F0_1234, 5'd9, 1'b1, 1'b1);
    run_op(3'b000, 32'h0000_0003, 5'd2, 1'b0, 1'b0);
    // Back-to-back with n=0: done stays high with the new result.
    run_op(3'b010, 32'h8765_4321, 5'd5, 1'b0, 1'b1);
    run_op(3'b100, 32'hCAFE_F00D, 5'd0, 1'b0, 1'b0);

    // Reset at SHIFT cycle 3: no done pulse afterwards.
    bus.start = 1'b1; bus.op = 3'b000; bus.data_in = 32'hFFFF_0001; bus.n = 5'd8;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    check("mid_busy", {31'b0, bus.busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_data", bus.data_out, 32'h0);
    for (int i = 0; i < 10; i++) begin
      check("abort_no_done", {30'b0, bus.done, bus.busy}, 32'd0);
      tick();
    end

    // Randomized operations against the reference model.
    for (int i = 0; i < 60; i++) begin
      r = $urandom;
      run_op(r[2:0], $urandom, (r[3] ? r[8:4] : {2'b0, r[6:4]}), r[9], r[10]);
    end
    tick();
    tick();
    check("final_idle", {30'b0, bus.done, bus.busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
